// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode-side
// valid/ready handshake with pre-sliced fields, and branch/jump redirect.
interface inst_fetch_if #(
    parameter int PC_WIDTH = 32
) ();
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_resp_valid;
    logic [31:0]         imem_resp_data;

    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst;
    logic [PC_WIDTH-1:0] inst_pc;
    logic [5:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [5:0]          func;

    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst, inst_pc, opcode, rs, rt, rd, shamt, func,
        input  inst_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst, inst_pc, opcode, rs, rt, rd, shamt, func,
        output inst_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, output register plus
// one-entry skid buffer, valid/ready delivery to decode, redirect flush.
module inst_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                req_valid_q, req_valid_d;
    logic [31:0]         inst_q, inst_d;
    logic [PC_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         skid_q, skid_d;
    logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                skid_valid_q, skid_valid_d;

    logic req_fire;
    logic consume;

    assign req_fire = req_valid_q && bus.imem_req_ready;
    assign consume  = inst_valid_q && bus.inst_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        if (bus.redirect_valid) begin
            // Flush wins over everything, including a decode handshake this cycle.
            pc_d         = bus.redirect_pc & ~(PC_WIDTH'(3));
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            unique case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
                S_WAIT:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    inst_d       = skid_q;
                    inst_pc_d    = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    inst_valid_d = 1'b0;
                end
            end

            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_WIDTH'(4);
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        // Output slot takes the word if it is free by the next edge.
                        if (!inst_valid_q || (consume && !skid_valid_q)) begin
                            inst_d       = bus.imem_resp_data;
                            inst_pc_d    = req_pc_q;
                            inst_valid_d = 1'b1;
                        end else begin
                            skid_d       = bus.imem_resp_data;
                            skid_pc_d    = req_pc_q;
                            skid_valid_d = 1'b1;
                        end
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_resp_valid) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // No new request while the skid holds a word: it has nowhere to land.
        req_valid_d = (state_d == S_REQ) && !skid_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            req_valid_q  <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.opcode         = inst_q[31:26];
    assign bus.rs             = inst_q[25:21];
    assign bus.rt             = inst_q[20:16];
    assign bus.rd             = inst_q[15:11];
    assign bus.shamt          = inst_q[10:6];
    assign bus.func           = inst_q[5:0];
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage that produces the instruction stream consumed by the decoder. Keeps the PC and issues one outstanding word request at a time to instruction memory. Buffers returned words in an output register plus a one-entry skid buffer. Presents the word and its pre-sliced opcode/func/rs/rt/rd/shamt fields to decode over a valid/ready handshake, and supports PC redirect from branch/jump resolution.

Parameters:
PC_WIDTH, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  PC_WIDTH  word-aligned fetch address
imem_resp_valid  input  1  read data valid (one pulse per accepted request, latency >= 1 cycle)
imem_resp_data  input  32  instruction word
inst_valid  output  1  output slot holds an instruction
inst_ready  input  1  decode consumes instruction
inst  output  32  instruction word
inst_pc  output  PC_WIDTH  address of inst
opcode  output  6  inst[31:26]
rs  output  5  inst[25:21]
rt  output  5  inst[20:16]
rd  output  5  inst[15:11]
shamt  output  5  inst[10:6]
func  output  6  inst[5:0]
redirect_valid  input  1  flush and refetch
redirect_pc  input  PC_WIDTH  new fetch address

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE, pc=RESET_PC, imem_req_valid=0, inst_valid=0, skid empty, inst=0, inst_pc=0. All field outputs are therefore 0.
- Field outputs are combinational slices of the inst register only. There is no other combinational path to the outputs.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_DROP.
- S_IDLE: go to S_REQ unconditionally on the next edge. If redirect_valid, also load pc.
- S_REQ: imem_req_valid = (skid empty); imem_addr = pc.
  - On valid&&ready: req_pc<=pc, pc<=pc+4 (mod 2^PC_WIDTH, wraps to 0), go to S_WAIT.
- S_WAIT: on imem_resp_valid the word is delivered (see Delivery), then go to S_REQ.
- S_DROP: the outstanding response is stale. On imem_resp_valid, discard it and go to S_REQ.
- Delivery priority:
  - If the output slot is empty, or is consumed this cycle (inst_valid&&inst_ready) with the skid empty, load inst/inst_pc={data, req_pc} and set inst_valid=1.
  - Otherwise write the word to the skid.
  - When the output slot is consumed while the skid is full, the skid moves to the output and the new response goes into the skid. This is safe because requests are not issued while the skid is full.
- Throughput: with 1-cycle memory latency and inst_ready held at 1, one instruction every 2 cycles.
- Redirect (redirect_valid=1) has priority over all other events in the same cycle:
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; inst_valid<=0; skid cleared.
  - A concurrent inst_ready handshake is ignored.
  - S_REQ with request accepted this cycle -> S_DROP. S_REQ with request not accepted -> stay in S_REQ.
  - S_WAIT without resp_valid -> S_DROP. S_WAIT with resp_valid -> response discarded, go to S_REQ.
  - S_DROP without resp_valid -> stay in S_DROP (pc updated). S_DROP with resp_valid -> S_REQ.
- Ordering: instructions leave in fetch order. No word is duplicated or lost except those flushed by redirect.
- inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- imem_req_valid, once asserted, is held with a stable imem_addr until accepted, unless a redirect occurs.
- Reset mid-operation: returns immediately to reset values. A memory response arriving after reset release while in S_IDLE/S_REQ is ignored.

Test Plan:
- Reset, RESET_PC=0, memory latency 1, words 0x00221821 @0, 0x00853021 @4, inst_ready=1 -> inst_pc 0 then 4. First beat: opcode=0, rs=1, rt=2, rd=3, func=0x21. Spacing is 2 cycles.
- Backpressure: inst_ready=0 for 10 cycles -> output holds 0x00221821 at inst_pc=0, skid holds the word at 4, imem_req_valid stays 0. On release, words at 0, 4, 8 emerge in order with no loss.
- Redirect in S_WAIT to 0x0000_0103 -> stale response dropped, next request addr 0x100, next inst_pc=0x100, inst_valid=0 during flush.
- Redirect in the same cycle as imem_resp_valid and inst_ready -> response discarded, held instruction not counted as consumed, next imem_addr equals the redirect target.
- PC wrap: redirect to 0xFFFF_FFFC -> fetch 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst_n=0 while in S_WAIT with both buffers full -> all outputs 0 immediately, first request after release at RESET_PC.
